// File: rtl/aes_pkg.sv
// Shared AES definitions: key/word/round types, round constants,
// forward S-box table and the inverse key scheduler state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [31:0]      word_t;
  typedef logic [3:0]       round_t;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} inv_ks_state_t;

  // Round constants for rounds 1..10, indexed by AES round number
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward AES S-box, shared with the encrypt path
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  word_t word,
  output word_t result
);

  assign result = {SBOX[word[31:24]], SBOX[word[23:16]],
                   SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key scheduler: loads the round-10 key and emits round
// keys 10 down to 0, one per accepted handshake, stepping the schedule
// backwards on the fly so the full key array is never stored.
module inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         clear,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  inv_ks_state_t state;

  word_t  w0, w1, w2, w3;
  word_t  p0, p1, p2, p3;
  word_t  rot_p3, sub_p3;
  logic [7:0] rcon_byte;
  key_t   prev_key;
  logic   handshake;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  // Undo the forward XOR chain; the recovered w3 of the previous key
  // feeds RotWord/SubWord exactly as it did in the forward direction.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  sub_word u_sub_word (
    .word   (rot_p3),
    .result (sub_p3)
  );

  // Only rounds 1..10 have a constant; round 0 never steps backwards.
  assign rcon_byte = (round_idx != 4'd0 && round_idx <= 4'(NUM_ROUNDS))
                   ? RCON[round_idx] : 8'h00;
  assign p0        = w0 ^ sub_p3 ^ {rcon_byte, 24'h0};
  assign prev_key  = {p0, p1, p2, p3};
  assign handshake = key_valid && key_ready;

  // Walk FSM with registered key, index and status outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            round_key <= last_key;
            round_idx <= round_t'(NUM_ROUNDS);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (round_idx != 4'd0) begin
              round_key <= prev_key;
              round_idx <= round_idx - 4'd1;
            end else begin
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          key_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_sched.sv
// Randomized self-checking bench for inv_key_sched: a forward AES-128 key
// expansion (S-box derived from GF(2^8) inversion) predicts every round key.
module tb_inv_key_sched;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         clear;
  logic [127:0] last_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  int vectors;
  int miscompares;

  logic [7:0]   model_sbox [256];
  logic [127:0] exp_keys [11];

  inv_key_sched dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .clear     (clear),
    .last_key  (last_key),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h00;
    logic [7:0] aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      model_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward key expansion: exp_keys[r] is the round-r key
  task automatic expand(input logic [127:0] cipher_key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = cipher_key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {model_sbox[t[31:24]], model_sbox[t[23:16]],
             model_sbox[t[15:8]], model_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] key);
    last_key = key;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; clear = 1'b0; key_ready = 1'b0; last_key = '0;
    #3;
    vectors++;
    if ({round_key, round_idx, key_valid, busy, done} !== 135'd0) begin
      miscompares++;
      $display("[TB] FAIL reset got key=%h idx=%0d kv=%b busy=%b done=%b want all zero",
               round_key, round_idx, key_valid, busy, done);
    end
    tick(); tick();
    n_rst = 1'b1;
    tick();
    vectors++;
    if ({key_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_idle got kv=%b busy=%b done=%b want 000", key_valid, busy, done);
    end
  endtask

  task automatic test_fips_walk();
    logic [127:0] want;
    int cycles;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    key_ready = 1'b1;
    pulse_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    cycles = 1;
    for (int k = 10; k >= 0; k--) begin
      case (k)
        10:      want = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        9:       want = 128'hac7766f319fadc2128d12941575c006e;
        1:       want = 128'ha0fafe1788542cb123a339392a6c7605;
        0:       want = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        default: want = exp_keys[k];
      endcase
      vectors++;
      if ({key_valid, busy, round_idx, round_key} !== {2'b11, 4'(k), want}) begin
        miscompares++;
        $display("[TB] FAIL fips_key got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                 key_valid, round_idx, round_key, k, want);
      end
      tick();
      cycles++;
    end
    vectors++;
    if ({done, key_valid, busy} !== 3'b101 || cycles != 12) begin
      miscompares++;
      $display("[TB] FAIL fips_done got done=%b kv=%b busy=%b cycles=%0d want 1 0 1 12",
               done, key_valid, busy, cycles);
    end
    tick();
    vectors++;
    if ({done, key_valid, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL fips_idle got done=%b kv=%b busy=%b want 000", done, key_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ck = rand_key();
    expand(ck);
    key_ready = 1'b1;
    pulse_start(exp_keys[10]);
    for (int k = 10; k >= 0; k--) begin
      vectors++;
      if ({key_valid, round_idx, round_key} !== {1'b1, 4'(k), exp_keys[k]}) begin
        miscompares++;
        $display("[TB] FAIL bp_key got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                 key_valid, round_idx, round_key, k, exp_keys[k]);
      end
      if (k == 7) begin
        key_ready = 1'b0;
        repeat (3) begin
          tick();
          vectors++;
          if ({key_valid, round_idx, round_key} !== {1'b1, 4'd7, exp_keys[7]}) begin
            miscompares++;
            $display("[TB] FAIL bp_hold got kv=%b idx=%0d key=%h want idx=7 key=%h",
                     key_valid, round_idx, round_key, exp_keys[7]);
          end
        end
        key_ready = 1'b1;
      end
      tick();
    end
    vectors++;
    if ({done, key_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL bp_done got done=%b kv=%b want 1 0", done, key_valid);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    logic [127:0] ck = rand_key();
    expand(ck);
    key_ready = 1'b1;
    pulse_start(exp_keys[10]);
    for (int k = 10; k >= 0; k--) begin
      vectors++;
      if ({key_valid, round_idx, round_key} !== {1'b1, 4'(k), exp_keys[k]}) begin
        miscompares++;
        $display("[TB] FAIL ign_key got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                 key_valid, round_idx, round_key, k, exp_keys[k]);
      end
      if (k == 5) pulse_start(~exp_keys[10]);
      else tick();
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ign_done got done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_start_clear_idle();
    last_key = rand_key();
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if ({key_valid, busy, done} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL start_clear cycle=%0d got kv=%b busy=%b done=%b want 000",
                 c, key_valid, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_clear_midwalk();
    logic [127:0] ck = rand_key();
    expand(ck);
    key_ready = 1'b1;
    pulse_start(exp_keys[10]);
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if ({key_valid, busy, done, round_idx, round_key} !== {3'b000, 4'd4, exp_keys[4]}) begin
      miscompares++;
      $display("[TB] FAIL clear got kv=%b busy=%b done=%b idx=%0d key=%h want 0 0 0 idx=4 key=%h",
               key_valid, busy, done, round_idx, round_key, exp_keys[4]);
    end
    tick();
    vectors++;
    if ({key_valid, done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL clear_nodone got kv=%b done=%b want 0 0", key_valid, done);
    end
    expand(~ck);
    pulse_start(exp_keys[10]);
    for (int k = 10; k >= 0; k--) begin
      vectors++;
      if ({key_valid, round_idx, round_key} !== {1'b1, 4'(k), exp_keys[k]}) begin
        miscompares++;
        $display("[TB] FAIL clear_fresh got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                 key_valid, round_idx, round_key, k, exp_keys[k]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_midwalk();
    logic [127:0] ck = rand_key();
    expand(ck);
    key_ready = 1'b1;
    pulse_start(exp_keys[10]);
    repeat (4) tick();
    vectors++;
    if (round_idx !== 4'd6) begin
      miscompares++;
      $display("[TB] FAIL rst_pre got idx=%0d want 6", round_idx);
    end
    #1 n_rst = 1'b0;
    #1;
    vectors++;
    if ({round_key, round_idx, key_valid, busy, done} !== 135'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid got key=%h idx=%0d kv=%b busy=%b done=%b want all zero",
               round_key, round_idx, key_valid, busy, done);
    end
    tick();
    n_rst = 1'b1;
    tick();
    expand(ck ^ 128'h5a);
    pulse_start(exp_keys[10]);
    for (int k = 10; k >= 0; k--) begin
      vectors++;
      if ({key_valid, round_idx, round_key} !== {1'b1, 4'(k), exp_keys[k]}) begin
        miscompares++;
        $display("[TB] FAIL rst_fresh got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                 key_valid, round_idx, round_key, k, exp_keys[k]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_roundtrip();
    for (int n = 0; n < 100; n++) begin
      logic [127:0] ck = rand_key();
      int k = 10;
      int budget = 0;
      expand(ck);
      key_ready = 1'b1;
      pulse_start(exp_keys[10]);
      while (k >= 0 && budget < 200) begin
        logic rdy;
        vectors++;
        if ({key_valid, round_idx, round_key} !== {1'b1, 4'(k), exp_keys[k]}) begin
          miscompares++;
          $display("[TB] FAIL trip n=%0d got kv=%b idx=%0d key=%h want idx=%0d key=%h",
                   n, key_valid, round_idx, round_key, k, exp_keys[k]);
        end
        rdy = 1'($urandom_range(0, 1));
        key_ready = rdy;
        tick();
        if (rdy) k--;
        budget++;
      end
      vectors++;
      if (budget >= 200 || done !== 1'b1 || round_key !== ck) begin
        miscompares++;
        $display("[TB] FAIL trip_end n=%0d got done=%b key=%h budget=%0d want done=1 key=%h",
                 n, done, round_key, budget, ck);
      end
      key_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    build_sbox();
    test_reset();
    test_fips_walk();
    test_backpressure();
    test_start_ignored();
    test_start_clear_idle();
    test_clear_midwalk();
    test_reset_midwalk();
    test_roundtrip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_key_sched.md
Name: inv_key_sched

Overview:
Sequential inverse AES-128 key scheduler for the decrypt datapath. Loads the round-10 (last) round key and walks the key schedule backwards, emitting one 128-bit round key per accepted handshake: round 10, 9, …, 0. The round-0 key emitted last is the cipher key. This feeds the inverse-cipher round logic on the fly, so the full 11-key array is never stored.

Parameters:
NUM_ROUNDS, 10, number of AES-128 rounds; fixed for AES-128 and not to be overridden.
KEY_W, 128, round key width in bits.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  load last_key and begin a walk; honoured only in IDLE
clear  input  1  synchronous abort; returns to IDLE the next edge and takes priority over all other inputs
last_key  input  128  round-10 key; sampled only on an accepted start
key_ready  input  1  consumer accepts round_key this cycle
round_key  output  128  current round key, registered
round_idx  output  4  AES round number of round_key (10 down to 0)
key_valid  output  1  round_key and round_idx are valid
busy  output  1  high in EMIT and DONE
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (n_rst=0, async): state=IDLE; round_key=0, round_idx=0, key_valid=0, busy=0, done=0.
- Word order: w0=bits[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
- Backward step from key r (r=10..1) to key r-1:
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
  - RotWord rotates bytes left by one.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. Rcon comes from a constant table indexed by round_idx. No multiplier.
- States:
  - IDLE: key_valid=0. If start: round_key<=last_key, round_idx<=10, go to EMIT. key_valid is high the cycle after start (1-cycle load latency).
  - EMIT: key_valid=1, and round_key/round_idx stay stable while key_ready=0.
    - On key_valid&&key_ready with round_idx>0: round_key<=backward step, round_idx<=round_idx-1. The next key is valid the next cycle, so back-to-back ready gives 1 key/cycle.
    - On handshake with round_idx==0: go to DONE, key_valid deasserts the next cycle.
  - DONE: done=1 for exactly one cycle, then go to IDLE. busy drops with IDLE.
- start in EMIT or DONE is ignored; no queuing.
- start and clear in the same cycle: clear wins and the state stays IDLE.
- clear: next state IDLE, key_valid=0, done=0. round_key and round_idx hold their stale values.
- Mid-walk async reset forces the reset values immediately. Outputs are not required to be valid after reset.
- round_idx never underflows: the decrement is gated by round_idx>0.
- Combinational path per step: one XOR chain plus 4 S-boxes, single cycle. No multicycle paths.

Decomposition:
- Shared package aes_pkg holds:
  - key_t (logic [127:0]), word_t (logic [31:0]), round_t (logic [3:0])
  - RCON table (10x8 bits), NUM_ROUNDS
  - state enum inv_ks_state_t {IDLE, EMIT, DONE}
- One sub-module, sub_word: 32-bit in/out, four parallel combinational AES forward S-boxes. Reused from the S-box lookup already in the encrypt path.
- The backward step is combinational inside inv_key_sched. The FSM and registers stay in a single always_ff.

Test Plan:
- Reset mid-walk: assert n_rst=0 at round_idx=6 -> all outputs 0 immediately. A new start after release resumes correctly from round 10.
- FIPS-197 walk, key_ready tied 1, start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 ->
  - cycle+1: idx 10, that key.
  - next: idx 9 = ac7766f319fadc2128d12941575c006e.
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after idx 0. Total 12 cycles from start to done.
- Backpressure: key_ready low for 3 cycles at idx 7 -> round_key/round_idx held constant, key_valid stays 1. The walk resumes with identical key values.
- Protocol edges: start pulsed at idx 5 -> ignored, sequence unchanged. start+clear together in IDLE -> remains IDLE, key_valid 0.
- Clear mid-walk at idx 4 -> IDLE next cycle, no done pulse. A new start with a different last_key produces the correct fresh sequence from idx 10.
- Round-trip against the encrypt-side key expansion: drive 100 random cipher keys through it and feed its round-10 output as last_key. The idx-k output must match expansion round k for all k, ending in the original key.
